// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests a byte at pc_in, bumps or redirects the
// pc register, and holds the fetched instruction until decode accepts it.
module fetch_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] pc_in,
  output logic [4:0] next_pc,
  output logic       pc_write,
  output logic       mem_req,
  output logic [4:0] mem_addr,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ack,
  input  logic       branch_taken,
  input  logic [4:0] branch_target,
  input  logic       halt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    UPDATE,
    HOLD,
    REDIRECT,
    HALT
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] target_q;

  // The redirect target is captured on the ack edge so decode may drop it afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      instr    <= 8'h00;
      target_q <= 5'd0;
    end else begin
      state <= state_next;
      if (state == REQ && mem_ready) begin
        instr <= mem_rdata;
      end
      if (state == HOLD && instr_ack && !halt && branch_taken) begin
        target_q <= branch_target;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = REQ;
      REQ:      if (mem_ready) state_next = UPDATE;
      UPDATE:   state_next = HOLD;
      HOLD: begin
        if (instr_ack) begin
          if (halt)              state_next = HALT;
          else if (branch_taken) state_next = REDIRECT;
          else                   state_next = REQ;
        end
      end
      REDIRECT: state_next = REQ;
      HALT:     state_next = HALT;
      default:  state_next = IDLE;
    endcase
  end

  // Handshake outputs depend on the state register alone; only the address paths see pc_in.
  always_comb begin
    mem_req     = 1'b0;
    pc_write    = 1'b0;
    instr_valid = 1'b0;
    mem_addr    = pc_in;
    next_pc     = pc_in;
    case (state)
      REQ:      mem_req = 1'b1;
      UPDATE: begin
        pc_write = 1'b1;
        next_pc  = 5'(pc_in + 5'd1);
      end
      HOLD:     instr_valid = 1'b1;
      REDIRECT: begin
        pc_write = 1'b1;
        next_pc  = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock, rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset; clears all state immediately when low.
REQ-004 pc_in  input  5  current program counter, driven by the pc register.
REQ-005 next_pc  output  5  value the pc register loads when pc_write=1.
REQ-006 pc_write  output  1  pc register write enable, one-cycle pulse.
REQ-007 mem_req  output  1  instruction memory read request.
REQ-008 mem_addr  output  5  instruction memory address.
REQ-009 mem_ready  input  1  memory response valid; mem_rdata is valid in the same cycle.
REQ-010 mem_rdata  input  8  instruction byte returned by memory.
REQ-011 instr  output  8  latched instruction presented to decode.
REQ-012 instr_valid  output  1  instr holds a fetched instruction not yet accepted.
REQ-013 instr_ack  input  1  decode accepts instr; sampled only while instr_valid=1.
REQ-014 branch_taken  input  1  accepted instruction redirects the PC; qualified by instr_ack.
REQ-015 branch_target  input  5  redirect address; qualified by instr_ack and branch_taken.
REQ-016 halt  input  1  accepted instruction is HALT; qualified by instr_ack.

Function
REQ-017 The FSM SHALL have exactly six states: IDLE, REQ, UPDATE, HOLD, REDIRECT, HALT.
REQ-018 IDLE: all outputs inactive; the FSM SHALL unconditionally go to REQ on the next edge.
REQ-019 REQ: mem_req=1 and mem_addr=pc_in; the FSM SHALL stay in REQ until mem_ready=1 at a rising edge.
REQ-020 On that edge, instr SHALL load mem_rdata and the FSM SHALL go to UPDATE.
REQ-021 UPDATE lasts exactly one cycle: pc_write=1, next_pc=(pc_in+1) mod 32, so 31 wraps to 0; the FSM then goes to HOLD.
REQ-022 HOLD: instr_valid=1 and instr SHALL remain stable until instr_ack=1 at an edge.
REQ-023 On ack, priority SHALL be halt > branch_taken > sequential.
REQ-024 On ack with halt=1, the FSM SHALL go to HALT.
REQ-025 On ack with branch_taken=1, the FSM SHALL go to REDIRECT.
REQ-026 On ack with neither set, the FSM SHALL go to REQ.
REQ-027 REDIRECT lasts exactly one cycle: pc_write=1 and next_pc=branch_target, registered on the ack edge; the FSM then goes to REQ.
REQ-028 HALT: all outputs inactive and instr_valid=0; only reset SHALL exit HALT.
REQ-029 mem_req, pc_write and instr_valid SHALL be decoded from the state register only, with no combinational path from any input.
REQ-030 In states other than UPDATE and REDIRECT, next_pc SHALL equal pc_in and pc_write SHALL be 0.
REQ-031 mem_ready outside REQ SHALL be ignored.
REQ-032 instr_ack, branch_taken and halt outside HOLD SHALL be ignored.
REQ-033 Minimum sequential fetch latency: a mem_ready arriving in the first REQ cycle SHALL yield instr_valid two cycles later.
REQ-034 Back-to-back throughput SHALL be one instruction per 3 cycles: REQ, UPDATE, HOLD, with immediate ack and zero-wait memory.

Reset
REQ-035 reset_n=0 SHALL immediately force state=IDLE, instr=8'h00, instr_valid=0, mem_req=0, pc_write=0.
REQ-036 While reset_n=0, next_pc SHALL equal pc_in and mem_addr SHALL equal pc_in.
REQ-037 Reset asserted in any state, including mid-REQ or HOLD, SHALL abort the operation with no pc_write pulse.
REQ-038 After reset_n rises, the FSM SHALL spend one cycle in IDLE before entering REQ.

Verification
REQ-039 Reset then pc_in=0, mem_rdata=8'hA5 with mem_ready in the first REQ cycle -> one UPDATE cycle with pc_write=1, next_pc=1; then instr=8'hA5, instr_valid=1.
REQ-040 pc_in=31, sequential fetch -> next_pc=0 during UPDATE.
REQ-041 mem_ready held low for 4 cycles in REQ -> mem_req=1 and mem_addr stable for all 4 cycles; pc_write=0 throughout.
REQ-042 HOLD with instr_ack=0 for 3 cycles, then ack with branch_taken=1, branch_target=5'd20 -> instr stable throughout; next cycle pc_write=1, next_pc=20; then REQ.
REQ-043 Ack with halt=1 and branch_taken=1 together -> HALT entered, no pc_write; mem_req stays 0 for 10 cycles; reset then restores IDLE.
REQ-044 reset_n driven low mid-REQ, asynchronously between clock edges -> mem_req=0 and instr_valid=0 immediately; no pc_write pulse afterward.
